// File: rtl/omc_pchan_ctrl.sv
// ---------------------------------------------------------------------------
// omc_pchan_ctrl
//
// Power-controller end of a P-Channel.  Turns single-beat power-state
// requests from the SoC power sequencer into 4-phase preq / paccept|pdeny
// handshakes towards the OMC low-power responder and tracks the last state
// the responder accepted.  When enabled, a pactive hint from the responder
// triggers an automatic request back to the RUN state.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   req_valid/req_state    power-state request; taken while req_ready is high
//   req_ready              high only while the FSM is idle
//   wake_en                enables the automatic wake-to-RUN on pactive
//   done, done_accept      1-cycle completion pulse; done_accept = accepted
//                          (holds until the next done)
//   cur_state              last accepted pstate
//   busy                   handshake in progress
//   timeout                sticky: handshake exceeded TIMEOUT cycles
//   proto_err              sticky: paccept and pdeny seen together
//   preq, pstate           P-Channel request outputs
//   paccept, pdeny         P-Channel responses (synchronous to aclk)
//   pactive                responder activity hint
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module omc_pchan_ctrl #(
  parameter int unsigned          PSTATE_W     = 3,
  parameter logic [PSTATE_W-1:0]  RUN_PSTATE   = 3'd0,
  parameter logic [PSTATE_W-1:0]  RESET_PSTATE = 3'd2,
  parameter int unsigned          TO_W         = 16,
  parameter int unsigned          TIMEOUT      = 1023
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                req_valid,
  input  logic [PSTATE_W-1:0] req_state,
  output logic                req_ready,
  input  logic                wake_en,
  output logic                done,
  output logic                done_accept,
  output logic [PSTATE_W-1:0] cur_state,
  output logic                busy,
  output logic                timeout,
  output logic                proto_err,
  output logic                preq,
  output logic [PSTATE_W-1:0] pstate,
  input  logic                paccept,
  input  logic                pdeny,
  input  logic                pactive
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(TIMEOUT);

  state_t              state_reg;
  logic [TO_W-1:0]     timer_reg;
  logic                acc_reg;

  // Request arbitration in IDLE: an explicit request always wins over the
  // automatic wake, and a wake is only raised when not already in RUN.
  logic                take_next;
  logic [PSTATE_W-1:0] target_next;

  always_comb begin
    take_next   = 1'b0;
    target_next = cur_state;
    if (req_valid) begin
      take_next   = 1'b1;
      target_next = req_state;
    end else if (wake_en && pactive && (cur_state != RUN_PSTATE)) begin
      take_next   = 1'b1;
      target_next = RUN_PSTATE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      acc_reg     <= 1'b0;
      req_ready   <= 1'b1;
      done        <= 1'b0;
      done_accept <= 1'b0;
      cur_state   <= RESET_PSTATE;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      proto_err   <= 1'b0;
      preq        <= 1'b0;
      pstate      <= RESET_PSTATE;
    end else begin
      done <= 1'b0;

      // Handshake watchdog: counts only while a handshake is outstanding and
      // just flags the condition; the FSM keeps waiting for the responder.
      if ((state_reg == ST_REQ) || (state_reg == ST_RELEASE)) begin
        if (timer_reg != {TO_W{1'b1}}) begin
          timer_reg <= timer_reg + 1'b1;
        end
        if (timer_reg == TIMEOUT_VAL) begin
          timeout <= 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (take_next) begin
            if (target_next == cur_state) begin
              // Already there: complete immediately without touching the channel.
              done        <= 1'b1;
              done_accept <= 1'b1;
            end else begin
              // pstate is launched here so it is stable a full cycle before preq.
              pstate    <= target_next;
              timer_reg <= '0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              state_reg <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          preq      <= 1'b1;
          state_reg <= ST_REQ;
        end

        ST_REQ: begin
          if (paccept && pdeny) begin
            // Illegal response: record it and treat as a deny.
            proto_err <= 1'b1;
            acc_reg   <= 1'b0;
            preq      <= 1'b0;
            state_reg <= ST_RELEASE;
          end else if (paccept) begin
            cur_state <= pstate;
            acc_reg   <= 1'b1;
            preq      <= 1'b0;
            state_reg <= ST_RELEASE;
          end else if (pdeny) begin
            acc_reg   <= 1'b0;
            preq      <= 1'b0;
            state_reg <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!paccept && !pdeny) begin
            done        <= 1'b1;
            done_accept <= acc_reg;
            // After a deny this restores the channel to the current state;
            // after an accept cur_state already equals pstate.
            pstate      <= cur_state;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omc_pchan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_omc_pchan_ctrl
//
// Directed bench for omc_pchan_ctrl.  A table of request records drives the
// main accept / deny / same-state / illegal-response cases; hand-written
// sequences cover auto-wake, request priority, timeout and mid-handshake
// reset.  A behavioural responder answers preq two cycles after it rises and
// releases one cycle after preq falls.
// ---------------------------------------------------------------------------
module tb_omc_pchan_ctrl;

  localparam int RESP_ACCEPT = 0;
  localparam int RESP_DENY   = 1;
  localparam int RESP_BOTH   = 2;
  localparam int RESP_SILENT = 3;

  logic       aclk;
  logic       aresetn;
  logic       req_valid;
  logic [2:0] req_state;
  logic       req_ready;
  logic       wake_en;
  logic       done;
  logic       done_accept;
  logic [2:0] cur_state;
  logic       busy;
  logic       timeout;
  logic       proto_err;
  logic       preq;
  logic [2:0] pstate;
  logic       paccept;
  logic       pdeny;
  logic       pactive;

  int checks = 0;
  int errors = 0;
  int resp_mode = RESP_ACCEPT;

  omc_pchan_ctrl #(
    .PSTATE_W     (3),
    .RUN_PSTATE   (3'd0),
    .RESET_PSTATE (3'd2),
    .TO_W         (16),
    .TIMEOUT      (8)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_state   (req_state),
    .req_ready   (req_ready),
    .wake_en     (wake_en),
    .done        (done),
    .done_accept (done_accept),
    .cur_state   (cur_state),
    .busy        (busy),
    .timeout     (timeout),
    .proto_err   (proto_err),
    .preq        (preq),
    .pstate      (pstate),
    .paccept     (paccept),
    .pdeny       (pdeny),
    .pactive     (pactive)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Responder: answers on the second cycle preq is seen high, releases on
  // the first cycle preq is seen low.
  initial begin
    int preq_cnt;
    preq_cnt = 0;
    paccept  = 1'b0;
    pdeny    = 1'b0;
    forever begin
      @(negedge aclk);
      if (preq) begin
        preq_cnt++;
        if (preq_cnt >= 2) begin
          paccept = (resp_mode == RESP_ACCEPT) || (resp_mode == RESP_BOTH);
          pdeny   = (resp_mode == RESP_DENY)   || (resp_mode == RESP_BOTH);
        end
      end else begin
        preq_cnt = 0;
        paccept  = 1'b0;
        pdeny    = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for the done pulse, observing the channel on the way.
  task automatic wait_done(output logic ok, output logic acc, output logic rose,
                           output logic [2:0] rise_pstate, output logic stable,
                           output int cycles);
    logic       prev_preq;
    logic [2:0] prev_pstate;
    ok          = 1'b0;
    acc         = 1'b0;
    rose        = 1'b0;
    rise_pstate = 3'd0;
    stable      = 1'b1;
    cycles      = 0;
    prev_preq   = preq;
    prev_pstate = pstate;
    for (int i = 1; i <= 200; i++) begin
      @(negedge aclk);
      req_valid = 1'b0;
      if (preq && !prev_preq) begin
        rose        = 1'b1;
        rise_pstate = pstate;
        if (pstate != prev_pstate) stable = 1'b0;
      end
      prev_preq   = preq;
      prev_pstate = pstate;
      if (done) begin
        ok     = 1'b1;
        acc    = done_accept;
        cycles = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] req;
    int         mode;
    logic       exp_acc;
    logic [2:0] exp_cur;
    logic       exp_hs;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic       ok, acc, rose, stable;
    logic [2:0] rp;
    int         cyc;
    int         n;
    int         to_at;
    logic       busy_seen;

    vecs[0] = '{req: 3'd4, mode: RESP_ACCEPT, exp_acc: 1'b1, exp_cur: 3'd4, exp_hs: 1'b1, exp_perr: 1'b0};
    vecs[1] = '{req: 3'd1, mode: RESP_DENY,   exp_acc: 1'b0, exp_cur: 3'd4, exp_hs: 1'b1, exp_perr: 1'b0};
    vecs[2] = '{req: 3'd4, mode: RESP_ACCEPT, exp_acc: 1'b1, exp_cur: 3'd4, exp_hs: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{req: 3'd6, mode: RESP_BOTH,   exp_acc: 1'b0, exp_cur: 3'd4, exp_hs: 1'b1, exp_perr: 1'b1};
    vecs[4] = '{req: 3'd6, mode: RESP_ACCEPT, exp_acc: 1'b1, exp_cur: 3'd6, exp_hs: 1'b1, exp_perr: 1'b1};
    vecs[5] = '{req: 3'd0, mode: RESP_ACCEPT, exp_acc: 1'b1, exp_cur: 3'd0, exp_hs: 1'b1, exp_perr: 1'b1};
    vecs[6] = '{req: 3'd4, mode: RESP_ACCEPT, exp_acc: 1'b1, exp_cur: 3'd4, exp_hs: 1'b1, exp_perr: 1'b1};

    aresetn   = 1'b0;
    req_valid = 1'b0;
    req_state = 3'd0;
    wake_en   = 1'b0;
    pactive   = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    check("rst_preq", int'(preq), 0);
    check("rst_pstate", int'(pstate), 2);
    check("rst_cur_state", int'(cur_state), 2);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_flags", int'({done, done_accept, busy, timeout, proto_err}), 0);
    @(negedge aclk);

    // Table-driven requests
    for (int v = 0; v < 7; v++) begin
      resp_mode = vecs[v].mode;
      check($sformatf("v%0d_req_ready", v), int'(req_ready), 1);
      req_valid = 1'b1;
      req_state = vecs[v].req;
      wait_done(ok, acc, rose, rp, stable, cyc);
      $display("vec %0d: req=%0d mode=%0d done_accept=%0d cur_state=%0d preq_rose=%0d cycles=%0d",
               v, vecs[v].req, vecs[v].mode, acc, cur_state, rose, cyc);
      check($sformatf("v%0d_done_seen", v), int'(ok), 1);
      check($sformatf("v%0d_done_accept", v), int'(acc), int'(vecs[v].exp_acc));
      check($sformatf("v%0d_cur_state", v), int'(cur_state), int'(vecs[v].exp_cur));
      check($sformatf("v%0d_preq_rose", v), int'(rose), int'(vecs[v].exp_hs));
      check($sformatf("v%0d_proto_err", v), int'(proto_err), int'(vecs[v].exp_perr));
      if (vecs[v].exp_hs) begin
        check($sformatf("v%0d_pstate_at_preq", v), int'(rp), int'(vecs[v].req));
        check($sformatf("v%0d_pstate_setup", v), int'(stable), 1);
      end else begin
        check($sformatf("v%0d_same_latency", v), cyc, 1);
      end
      @(negedge aclk);
      check($sformatf("v%0d_done_pulse", v), int'(done), 0);
      check($sformatf("v%0d_accept_hold", v), int'(done_accept), int'(vecs[v].exp_acc));
      check($sformatf("v%0d_pstate_idle", v), int'(pstate), int'(vecs[v].exp_cur));
      check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
    end

    // Auto-wake from state 4 to RUN
    resp_mode = RESP_ACCEPT;
    wake_en = 1'b1;
    pactive = 1'b1;
    wait_done(ok, acc, rose, rp, stable, cyc);
    $display("wake: done_accept=%0d cur_state=%0d pstate_at_preq=%0d", acc, cur_state, rp);
    check("wake_done_seen", int'(ok), 1);
    check("wake_pstate_at_preq", int'(rp), 0);
    check("wake_cur_state", int'(cur_state), 0);
    busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (busy || preq) busy_seen = 1'b1;
    end
    check("wake_in_run_idle", int'(busy_seen), 0);
    wake_en = 1'b0;

    // Back to 4, then explicit request 5 together with a wake condition
    req_valid = 1'b1;
    req_state = 3'd4;
    wait_done(ok, acc, rose, rp, stable, cyc);
    check("prio_setup_cur_state", int'(cur_state), 4);
    @(negedge aclk);
    wake_en   = 1'b1;
    req_valid = 1'b1;
    req_state = 3'd5;
    wait_done(ok, acc, rose, rp, stable, cyc);
    $display("prio first: pstate_at_preq=%0d cur_state=%0d", rp, cur_state);
    check("prio_first_pstate", int'(rp), 5);
    check("prio_first_cur_state", int'(cur_state), 5);
    wait_done(ok, acc, rose, rp, stable, cyc);
    $display("prio second: pstate_at_preq=%0d cur_state=%0d", rp, cur_state);
    check("prio_second_done", int'(ok), 1);
    check("prio_second_pstate", int'(rp), 0);
    check("prio_second_cur_state", int'(cur_state), 0);
    wake_en = 1'b0;
    pactive = 1'b0;
    @(negedge aclk);

    // Timeout with a silent responder, then reset mid-handshake
    resp_mode = RESP_SILENT;
    req_valid = 1'b1;
    req_state = 3'd5;
    n = 0;
    to_at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      req_valid = 1'b0;
      if (preq) n++;
      if (n == 7 && to_at == 0) check("to_not_early", int'(timeout), 0);
      if (timeout) begin
        to_at = n;
        break;
      end
    end
    $display("timeout: set after %0d preq cycles, preq=%0d", to_at, preq);
    check("to_set", int'(timeout), 1);
    check("to_window", int'((to_at >= 8) && (to_at <= 11)), 1);
    check("to_preq_held", int'(preq), 1);
    repeat (3) @(negedge aclk);
    check("to_still_waiting", int'(preq && busy && timeout), 1);
    aresetn = 1'b0;
    @(negedge aclk);
    $display("mid reset: preq=%0d pstate=%0d cur_state=%0d", preq, pstate, cur_state);
    check("mrst_preq", int'(preq), 0);
    check("mrst_pstate", int'(pstate), 2);
    check("mrst_cur_state", int'(cur_state), 2);
    check("mrst_flags", int'({busy, timeout, proto_err, done_accept}), 0);
    check("mrst_req_ready", int'(req_ready), 1);
    aresetn = 1'b1;
    resp_mode = RESP_ACCEPT;
    repeat (2) @(negedge aclk);

    // Recovery after reset
    req_valid = 1'b1;
    req_state = 3'd3;
    wait_done(ok, acc, rose, rp, stable, cyc);
    $display("recovery: done_accept=%0d cur_state=%0d", acc, cur_state);
    check("rec_done_accept", int'(ok && acc), 1);
    check("rec_cur_state", int'(cur_state), 3);
    check("rec_timeout_clear", int'(timeout), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
